fir_load_scheduler: RTL and testbench

Sequencing controller for the shared FIR datapath behind the AHB-Lite slave register file. Arbitrates between coefficient-reload requests (`new_coefficient_set`) and sample requests (`data_ready`), and issues single-cycle `load_coeff` and `sample_go` commands to the FIR core. Each command is gated on the core's `modwait` handshake. Reports completion, faults and watchdog timeouts back to the register file.

---
 rtl/fir_load_scheduler_if.sv | 31 +++
 rtl/fir_load_scheduler.sv | 148 ++++++++++++++
 tb/tb_fir_load_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_load_scheduler_if.sv
// Handshake bundle between the register file / FIR core and the load scheduler.
// master: register file + core side (drives requests and core status).
// slave : scheduler side (drives command pulses and status flags).
interface fir_load_scheduler_if #(
  parameter int COEFF_COUNT = 4
);
  localparam int CW = (COEFF_COUNT > 1) ? $clog2(COEFF_COUNT) : 1;

  logic          new_coefficient_set;
  logic          data_ready;
  logic          modwait;
  logic          err;
  logic          fault_clr;
  logic          load_coeff;
  logic [CW-1:0] coefficient_num;
  logic          coeff_clear;
  logic          sample_go;
  logic          busy;
  logic          fault;
  logic          timeout;

  modport master (
    output new_coefficient_set, data_ready, modwait, err, fault_clr,
    input  load_coeff, coefficient_num, coeff_clear, sample_go, busy, fault, timeout
  );

  modport slave (
    input  new_coefficient_set, data_ready, modwait, err, fault_clr,
    output load_coeff, coefficient_num, coeff_clear, sample_go, busy, fault, timeout
  );
endinterface

// File: rtl/fir_load_scheduler.sv
// Sequencing controller for the shared FIR datapath.
// Arbitrates coefficient reloads against sample requests, issues one-cycle
// load_coeff / sample_go commands gated on the core's modwait handshake, and
// reports faults back to the register file.
// Optional feature macro: FIR_SCHED_WATCHDOG_EN adds the wait-state watchdog
// (wait counter, timeout abort and the sticky timeout flag).
module fir_load_scheduler #(
  parameter int COEFF_COUNT = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_load_scheduler_if.slave  bus
);
  localparam int            CW       = (COEFF_COUNT > 1) ? $clog2(COEFF_COUNT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(COEFF_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LWAIT,
    S_DONE,
    S_SAMPLE,
    S_SWAIT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic          r_wait_first;
  logic          r_fault;
  logic          w_in_wait;
  logic          w_err_abort;
  logic          w_wd_fire;
  logic          w_abort;
  logic          w_core_done;

  assign w_in_wait   = (r_state == S_LWAIT) || (r_state == S_SWAIT);
  assign w_err_abort = w_in_wait && bus.err;
  assign w_abort     = w_err_abort || w_wd_fire;
  // The first wait cycle ignores modwait: the core needs one cycle to raise it.
  assign w_core_done = !r_wait_first && !bus.modwait;

`ifdef FIR_SCHED_WATCHDOG_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] r_wcnt;
  logic          r_timeout;

  // Fires on the TIMEOUT-th wait cycle so the state leaves at the next edge.
  assign w_wd_fire = w_in_wait && (r_wcnt == TW'(TIMEOUT - 1));

  // Wait counter: zero outside wait states, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (rst)            r_wcnt <= '0;
    else if (w_in_wait) r_wcnt <= r_wcnt + 1'b1;
    else                r_wcnt <= '0;
  end

  // Sticky timeout flag; a new watchdog abort beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_wd_fire || (r_timeout && !bus.fault_clr);
  end

  assign bus.timeout = r_timeout;
`else
  // TIMEOUT only matters with the watchdog built in.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT == 0);
  assign w_wd_fire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register, coefficient index and first-wait-cycle marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      // LOAD/SAMPLE always hand over to a wait state, so the next cycle is its first.
      r_wait_first <= (r_state == S_LOAD) || (r_state == S_SAMPLE);
    end
  end

  // Next-state and index logic; reload wins over sample when both are pending.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.modwait) begin
          if (bus.new_coefficient_set) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = '0;
          end else if (bus.data_ready) begin
            w_state_nxt = S_SAMPLE;
          end
        end
      end
      S_LOAD:   w_state_nxt = S_LWAIT;
      S_LWAIT: begin
        if (w_abort) begin
          // An aborted reload restarts from coefficient 0 if still requested.
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_core_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      S_SAMPLE: w_state_nxt = S_SWAIT;
      S_SWAIT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_core_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Sticky fault flag; a new abort beats a coincident fault_clr.
  always_ff @(posedge clk) begin
    if (rst) r_fault <= 1'b0;
    else     r_fault <= w_abort || (r_fault && !bus.fault_clr);
  end

  // Outputs decode registered state only.
  assign bus.load_coeff      = (r_state == S_LOAD);
  assign bus.coeff_clear     = (r_state == S_DONE);
  assign bus.sample_go       = (r_state == S_SAMPLE);
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.coefficient_num = r_idx;
  assign bus.fault           = r_fault;
endmodule

// File: tb/tb_fir_load_scheduler.sv
// Directed bench for fir_load_scheduler: pulse scoreboard plus timing/flag checks.
module tb_fir_load_scheduler;
  localparam int CC = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_load_scheduler_if #(.COEFF_COUNT(CC)) ifc ();

  fir_load_scheduler #(.COEFF_COUNT(CC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_err    = 0;
  int sb[$];          // expected pulses: 10+idx load, 20 clear, 30 sample
  int core_lat   = 1; // cycles the core model holds modwait after a command
  bit core_stuck = 0; // core keeps modwait high after the next command

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL %s observed=no-event expected=event-within-bound", tag);
  endtask

  function automatic logic [31:0] outs();
    return 32'({ifc.load_coeff, ifc.coeff_clear, ifc.sample_go, ifc.busy,
                ifc.fault, ifc.timeout, ifc.coefficient_num});
  endfunction

  // Core model: modwait high core_lat cycles after the cycle carrying a command.
  initial begin : core_model
    int cnt;
    bit stuck_on;
    bit mw;
    cnt = 0;
    stuck_on = 0;
    ifc.modwait = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cnt > 0) begin mw = 1'b1; cnt--; end
      else mw = 1'b0;
      if (!core_stuck) stuck_on = 1'b0;
      if (ifc.load_coeff || ifc.sample_go) begin
        cnt = core_lat;
        if (core_stuck) stuck_on = 1'b1;
      end
      ifc.modwait = mw || stuck_on;
    end
  end

  // Pulse monitor: every command pulse must match the head of the scoreboard.
  initial begin : monitor
    int code;
    int n;
    forever begin
      @(negedge clk);
      n = int'(ifc.load_coeff) + int'(ifc.coeff_clear) + int'(ifc.sample_go);
      if (n != 0) begin
        chk("one_pulse", n, 1);
        code = ifc.load_coeff ? 10 + int'(ifc.coefficient_num) : (ifc.coeff_clear ? 20 : 30);
        if (sb.size() == 0) chk("sb_unexpected", code, 0);
        else chk("sb_pulse", code, sb.pop_front());
      end
    end
  end

  // One clock; the register file drops each request once it is served.
  task automatic step();
    @(posedge clk); #2;
    if (ifc.coeff_clear) ifc.new_coefficient_set = 1'b0;
    if (ifc.sample_go)   ifc.data_ready = 1'b0;
  endtask

  // Counts busy cycles until the scheduler returns to IDLE.
  task automatic run_to_idle(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ifc.busy) n++;
      else if (n > 0) return;
    end
    tmo(tag);
  endtask

  task automatic wait_load(input string tag, input int idx);
    for (int i = 0; i < 100; i++) begin
      step();
      if (ifc.load_coeff && int'(ifc.coefficient_num) == idx) return;
    end
    tmo(tag);
  endtask

  task automatic push_reload();
    for (int i = 0; i < CC; i++) sb.push_back(10 + i);
    sb.push_back(20);
  endtask

  initial begin : global_bound
    #500000;
    $display("FAIL global_bound observed=still-running expected=finished");
    $fatal(1);
  end

  initial begin : main
    int n;
    ifc.new_coefficient_set = 1'b0;
    ifc.data_ready          = 1'b0;
    ifc.err                 = 1'b0;
    ifc.fault_clr           = 1'b0;

    // Reset and idle
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outs", outs(), 0);
    end

    // Plain reload, core drops modwait one cycle after each load
    push_reload();
    ifc.new_coefficient_set = 1'b1;
    run_to_idle("reload_tmo", n);
    chk("reload_cycles", n, 13);
    chk("reload_sb_empty", sb.size(), 0);
    chk("reload_idx_hold", ifc.coefficient_num, CC - 1);

    // Reload and sample together: reload first, sample right after IDLE
    push_reload();
    sb.push_back(30);
    ifc.new_coefficient_set = 1'b1;
    ifc.data_ready          = 1'b1;
    run_to_idle("both_reload_tmo", n);
    chk("both_reload_cycles", n, 13);
    step();
    chk("both_sample_go", ifc.sample_go, 1);
    run_to_idle("both_sample_tmo", n);
    chk("both_sample_rest", n, 2);
    chk("both_sb_empty", sb.size(), 0);

    // err during LWAIT of coefficient 2, request held
    sb.push_back(10); sb.push_back(11); sb.push_back(12);
    push_reload();
    ifc.new_coefficient_set = 1'b1;
    wait_load("err_wait_load2", 2);
    step();
    ifc.err = 1'b1;
    step();
    ifc.err = 1'b0;
    chk("err_fault", ifc.fault, 1);
    chk("err_timeout", ifc.timeout, 0);
    chk("err_busy", ifc.busy, 0);
    chk("err_idx", ifc.coefficient_num, 0);
    run_to_idle("err_restart_tmo", n);
    chk("err_restart_cycles", n, 13);
    chk("err_sb_empty", sb.size(), 0);
    chk("err_fault_sticky", ifc.fault, 1);
    ifc.fault_clr = 1'b1;
    step();
    ifc.fault_clr = 1'b0;
    chk("err_fault_clr", ifc.fault, 0);

    // Core stuck busy after sample_go
    sb.push_back(30);
    core_stuck = 1'b1;
    ifc.data_ready = 1'b1;
`ifdef FIR_SCHED_WATCHDOG_EN
    run_to_idle("wd_tmo", n);
    chk("wd_busy_cycles", n, 1 + TO);
    chk("wd_fault", ifc.fault, 1);
    chk("wd_timeout", ifc.timeout, 1);
    core_stuck = 1'b0;
    step();
    ifc.fault_clr = 1'b1;
    step();
    ifc.fault_clr = 1'b0;
    chk("wd_clr_fault", ifc.fault, 0);
    chk("wd_clr_timeout", ifc.timeout, 0);
`else
    repeat (30) step();
    chk("stuck_busy", ifc.busy, 1);
    chk("stuck_fault", ifc.fault, 0);
    chk("stuck_timeout", ifc.timeout, 0);
    core_stuck = 1'b0;
    run_to_idle("stuck_release_tmo", n);
    chk("stuck_release_fault", ifc.fault, 0);
`endif
    chk("stuck_sb_empty", sb.size(), 0);

    // Reset during the second LOAD of a reload
    sb.push_back(10); sb.push_back(11);
    ifc.new_coefficient_set = 1'b1;
    wait_load("rst_wait_load1", 1);
    rst = 1'b1;
    step();
    chk("rst_mid_outs", outs(), 0);
    rst = 1'b0;
    push_reload();
    run_to_idle("rst_restart_tmo", n);
    chk("rst_restart_cycles", n, 13);

    repeat (3) step();
    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
